// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C responder bridging transfers to a byte-wide register port
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int FILT_LEN = 3,
  parameter int SDA_HOLD = 4,
  parameter int PTR_WID = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclIn,
  input  logic               sdaIn,
  output logic               sdaOut,
  output logic [PTR_WID-1:0] regAddr,
  output logic [7:0]         regWrData,
  output logic               regWrEn,
  output logic               regRdEn,
  input  logic [7:0]         regRdData,
  output logic               busy,
  output logic               done,
  output logic [7:0]         debug
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR, WR_ACK, RD_LOAD, RD, RD_MACK, IGNORE
  } state_t;
  localparam int HW = $clog2(SDA_HOLD + 1);
  state_t state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
  logic scl_f_q, scl_f_d, sda_f_q, sda_f_d, scl_p_q, sda_p_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sr_q, sr_d, wr_data_q, wr_data_d;
  logic [PTR_WID-1:0] addr_q, addr_d;
  logic sda_out_q, sda_out_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic busy_q, busy_d, done_q, done_d, rw_q, rw_d, skip_q, skip_d;
  logic scl_rise, scl_fall, start, stop, tick;
  logic [7:0] rx_byte;
  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  // SCL must have been high on both samples so a coincident SCL rise counts as data
  assign start = scl_f_q & scl_p_q & ~sda_f_q & sda_p_q;
  assign stop = scl_f_q & scl_p_q & sda_f_q & ~sda_p_q;
  assign tick = hold_q == HW'(1);
  assign rx_byte = {sr_q[6:0], sda_f_q};
  assign sdaOut = sda_out_q;
  assign regAddr = addr_q;
  assign regWrData = wr_data_q;
  assign regWrEn = wr_en_q;
  assign regRdEn = rd_en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign debug = {scl_f_q, bit_cnt_q, state_q};
  always_comb begin
    scl_f_d = &scl_hist_q | (scl_f_q & |scl_hist_q);
    sda_f_d = &sda_hist_q | (sda_f_q & |sda_hist_q);
    hold_d = scl_fall ? HW'(SDA_HOLD) : (hold_q != '0) ? hold_q - 1'b1 : hold_q;
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d = rd_en_q ? regRdData : sr_q;
    wr_data_d = wr_data_q;
    addr_d = (wr_en_q | rd_en_q) ? addr_q + 1'b1 : addr_q;
    sda_out_d = sda_out_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    rw_d = rw_q;
    skip_d = skip_q;
    if (start) begin
      state_d = ADDR;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
    end else if (stop) begin
      state_d = IDLE;
      sda_out_d = 1'b1;
      busy_d = 1'b0;
      done_d = busy_q;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sr_d = rx_byte;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
            busy_d = busy_q | (rx_byte[7:1] == DEV_ADDR);
            rw_d = rx_byte[0];
            skip_d = busy_q;
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (tick) sda_out_d = 1'b0;
          if (scl_rise) begin
            state_d = (state_q == WR_ACK) ? WR : rw_q ? RD_LOAD : skip_q ? WR : PTR;
            bit_cnt_d = '0;
            rd_en_d = (state_q == ADDR_ACK) & rw_q;
          end
        end
        PTR, WR: begin
          if (tick) sda_out_d = 1'b1;
          if (scl_rise) begin
            sr_d = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_d = WR_ACK;
              if (state_q == PTR) addr_d = PTR_WID'(rx_byte);
              else begin
                wr_data_d = rx_byte;
                wr_en_d = 1'b1;
              end
            end
          end
        end
        RD_LOAD: if (tick) begin
          sda_out_d = sr_q[7];
          bit_cnt_d = '0;
          state_d = RD;
        end
        RD: if (tick) begin
          sda_out_d = (bit_cnt_q == 3'd7) ? 1'b1 : sr_q[6];
          sr_d = {sr_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d = (bit_cnt_q == 3'd7) ? RD_MACK : RD;
        end
        RD_MACK: if (scl_rise) begin
          state_d = sda_f_q ? IGNORE : RD_LOAD;
          rd_en_d = ~sda_f_q;
        end
        default: if (tick) sda_out_d = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
      hold_q <= '0;
      state_q <= IDLE;
      bit_cnt_q <= '0;
      sr_q <= '0;
      wr_data_q <= '0;
      addr_q <= '0;
      sda_out_q <= 1'b1;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rw_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], sclIn};
      sda_sync_q <= {sda_sync_q[0], sdaIn};
      scl_hist_q <= {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
      scl_f_q <= scl_f_d;
      sda_f_q <= sda_f_d;
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
      hold_q <= hold_d;
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q <= sr_d;
      wr_data_q <= wr_data_d;
      addr_q <= addr_d;
      sda_out_q <= sda_out_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rw_q <= rw_d;
      skip_q <= skip_d;
    end
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: directed I2C transactions against i2c_slave_regs with a bench-side bus master
module tb_i2c_slave_regs;
  localparam int Q = 10;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
  logic sda_out, reg_wr_en, reg_rd_en, busy, done, sda_line;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data, debug;
  logic [7:0] rom [256];
  logic [7:0] wl_a [64];
  logic [7:0] wl_d [64];
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, busy_cyc = 0, low_cyc = 0;
  int total = 0, passed = 0;
  typedef struct {
    logic [7:0] dev, ptr, d0, d1, exp_addr;
    logic match;
  } wvec_t;
  wvec_t vt [4];
  assign sda_line = m_sda & sda_out;
  assign reg_rd_data = rom[reg_addr];
  i2c_slave_regs dut (
    .clk(clk), .rst(rst), .sclIn(m_scl), .sdaIn(sda_line), .sdaOut(sda_out),
    .regAddr(reg_addr), .regWrData(reg_wr_data), .regWrEn(reg_wr_en),
    .regRdEn(reg_rd_en), .regRdData(reg_rd_data), .busy(busy), .done(done),
    .debug(debug)
  );
  initial forever #5 clk = ~clk;
  always @(negedge clk) begin
    if (reg_wr_en) begin
      wl_a[wr_cnt[5:0]] <= reg_addr;
      wl_d[wr_cnt[5:0]] <= reg_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (!sda_out) low_cyc <= low_cyc + 1;
  end
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start;
    m_sda = 1'b1; wq(2 * Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask
  task automatic i2c_stop;
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(2 * Q);
  endtask
  task automatic wbit(input logic b, input logic glitch);
    m_sda = b; wq(Q);
    m_scl = 1'b1;
    if (glitch) begin
      wq(5); m_scl = 1'b0; wq(2); m_scl = 1'b1; wq(2 * Q - 7);
    end else wq(2 * Q);
    m_scl = 1'b0; wq(Q);
  endtask
  task automatic rbit(output logic b);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    b = sda_line; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask
  task automatic wbyte(input logic [7:0] d, input int gl, output logic nack);
    for (int i = 7; i >= 0; i--) wbit(d[i], i == gl);
    rbit(nack);
  endtask
  task automatic rbyte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(nack, 1'b0);
  endtask
  initial begin
    logic n0, n1, n2, n3;
    logic [7:0] b0, b1, b2;
    int w0, r0, d0, bz, lo;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
    rom[8'h20] = 8'h11; rom[8'h21] = 8'h22; rom[8'h22] = 8'h33;
    vt[0] = '{8'hA0, 8'h10, 8'h5A, 8'hC3, 8'h12, 1'b1};
    vt[1] = '{8'hA0, 8'hFF, 8'h01, 8'h02, 8'h01, 1'b1};
    vt[2] = '{8'hA2, 8'h00, 8'h77, 8'h88, 8'h01, 1'b0};
    vt[3] = '{8'hA0, 8'h80, 8'h00, 8'hFF, 8'h82, 1'b1};
    wq(5); rst = 1'b0; wq(2);
    chk("rst_sda", int'(sda_out), 1);
    chk("rst_addr", int'(reg_addr), 0);
    chk("rst_wdata", int'(reg_wr_data), 0);
    chk("rst_strobes", int'({reg_wr_en, reg_rd_en, busy, done}), 0);
    chk("rst_state", int'(debug[3:0]), 0);
    for (int v = 0; v < 4; v++) begin
      w0 = wr_cnt; d0 = done_cnt; bz = busy_cyc; lo = low_cyc;
      i2c_start;
      wbyte(vt[v].dev, -1, n0);
      wbyte(vt[v].ptr, -1, n1);
      wbyte(vt[v].d0, -1, n2);
      wbyte(vt[v].d1, -1, n3);
      i2c_stop; wq(5);
      chk($sformatf("v%0d_acks", v), int'({n0, n1, n2, n3}), vt[v].match ? 0 : 15);
      chk($sformatf("v%0d_wrcnt", v), wr_cnt - w0, vt[v].match ? 2 : 0);
      if (vt[v].match) begin
        chk($sformatf("v%0d_wr0", v), int'({wl_a[w0[5:0]], wl_d[w0[5:0]]}), int'({vt[v].ptr, vt[v].d0}));
        chk($sformatf("v%0d_wr1", v), int'({wl_a[6'(w0 + 1)], wl_d[6'(w0 + 1)]}), int'({8'(vt[v].ptr + 8'd1), vt[v].d1}));
      end
      chk($sformatf("v%0d_addr", v), int'(reg_addr), int'(vt[v].exp_addr));
      chk($sformatf("v%0d_done", v), done_cnt - d0, int'(vt[v].match));
      chk($sformatf("v%0d_busy", v), int'(busy_cyc > bz), int'(vt[v].match));
      chk($sformatf("v%0d_sdalow", v), int'(low_cyc > lo), int'(vt[v].match));
    end
    r0 = rd_cnt; d0 = done_cnt;
    i2c_start; wbyte(8'hA0, -1, n0); wbyte(8'h20, -1, n1);
    i2c_start; wbyte(8'hA1, -1, n2);
    rbyte(1'b0, b0); rbyte(1'b0, b1); rbyte(1'b1, b2);
    i2c_stop; wq(5);
    chk("rd_acks", int'({n0, n1, n2}), 0);
    chk("rd_bytes", int'({b0, b1, b2}), 32'h112233);
    chk("rd_en_cnt", rd_cnt - r0, 3);
    chk("rd_addr", int'(reg_addr), 8'h23);
    chk("rd_done", done_cnt - d0, 1);
    w0 = wr_cnt;
    i2c_start; wbyte(8'hA0, -1, n0); wbyte(8'h50, -1, n1); wbyte(8'h96, 4, n2);
    i2c_stop; wq(5);
    chk("gl_acks", int'({n0, n1, n2}), 0);
    chk("gl_wrcnt", wr_cnt - w0, 1);
    chk("gl_wr", int'({wl_a[w0[5:0]], wl_d[w0[5:0]]}), 16'h5096);
    w0 = wr_cnt; d0 = done_cnt;
    i2c_start; wbyte(8'hA0, -1, n0); wbyte(8'h30, -1, n1);
    wbit(1'b1, 1'b0); wbit(1'b0, 1'b0); wbit(1'b1, 1'b0); wbit(1'b1, 1'b0);
    i2c_stop; wq(5);
    chk("ab_wrcnt", wr_cnt - w0, 0);
    chk("ab_state", int'(debug[3:0]), 0);
    chk("ab_addr_busy", int'({reg_addr, busy}), 9'h060);
    chk("ab_done", done_cnt - d0, 1);
    i2c_start; wbyte(8'hA0, -1, n0); wbyte(8'h40, -1, n1);
    i2c_start; wbyte(8'hA1, -1, n2);
    rbyte(1'b0, b0); rbyte(1'b1, b1);
    i2c_stop; wq(5);
    chk("lb_errnack", int'(n0 | n1 | n2), 0);
    chk("lb_rdbuf", int'({b0, b1}), 16'hE5E4);
    i2c_start;
    for (int i = 7; i >= 0; i--) wbit(n0 ^ n0 | (8'hA1 >> i) & 1'b1, 1'b0);
    m_sda = 1'b1;
    for (int k = 0; k < 100 && sda_out !== 1'b0; k++) wq(1);
    chk("rs_acklow", int'(sda_out), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rs_release", int'(sda_out), 1);
    chk("rs_busy_addr", int'({busy, reg_addr}), 0);
    wq(2); rst = 1'b0; m_scl = 1'b1; wq(4 * Q);
    chk("rs_idle", int'({sda_out, debug[3:0]}), 16);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
